// File: rtl/ifetch.sv
// Instruction fetch unit: owns the PC, issues word fetches over a
// req/gnt/rvalid handshake, buffers returned words in a small FIFO and hands
// them to decode with valid/ready. A redirect flushes the buffer and marks
// every still-pending response as stale so it is dropped on arrival.
module ifetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C     = CW'(FIFO_DEPTH);
    localparam logic [CW:0]   DEPTH_W     = (CW + 1)'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST_PTR    = PW'(FIFO_DEPTH - 1);
    localparam logic [31:0]   RESET_PC_AL = {RESET_PC[31:2], 2'b00};

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } entry_t;

    entry_t        fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;        // buffered entries
    logic [CW-1:0] outstanding;  // granted, response not yet seen (stale ones included)
    logic [CW-1:0] discard;      // subset of outstanding whose responses must be dropped
    logic [31:0]   pc_q;         // next fetch address
    logic [31:0]   resp_pc;      // address of the next non-stale response
    logic [31:0]   redirect_al;
    logic [CW:0]   in_use;
    logic          issue, push, pop, fifo_full;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    assign redirect_al = redirect_pc & 32'hFFFF_FFFC;

    // Credit: never have more fetches in flight plus buffered than slots,
    // so a returning word always has a free entry waiting for it.
    assign in_use   = {1'b0, outstanding} + {1'b0, count};
    assign mem_req  = rst_n & ~redirect & (in_use < DEPTH_W);
    assign mem_addr = pc_q;
    assign issue    = mem_req & mem_gnt;

    assign push        = mem_rvalid & ~redirect & (discard == '0);
    assign instr_valid = (count != '0);
    assign pop         = instr_valid & instr_ready & ~redirect;
    assign fifo_full   = (count == DEPTH_C);

    assign instr    = instr_valid ? fifo_mem[rd_ptr].word : '0;
    assign instr_pc = instr_valid ? fifo_mem[rd_ptr].pc   : '0;

    // PC, response tracking, FIFO pointers; redirect overrides everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC_AL;
            resp_pc     <= RESET_PC_AL;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding + CW'(issue) - CW'(mem_rvalid);
            if (redirect) begin
                pc_q    <= redirect_al;
                resp_pc <= redirect_al;
                rd_ptr  <= '0;
                wr_ptr  <= '0;
                count   <= '0;
                // Already-stale responses are counted inside outstanding, so
                // everything still pending after this cycle's response becomes
                // stale. Stacking redirects therefore never over-counts.
                discard <= outstanding - CW'(mem_rvalid);
            end else begin
                if (issue)
                    pc_q <= pc_q + 32'd4;
                if (mem_rvalid && (discard != '0))
                    discard <= discard - CW'(1);
                if (push) begin
                    wr_ptr  <= ptr_inc(wr_ptr);
                    resp_pc <= resp_pc + 32'd4;
                end
                if (pop)
                    rd_ptr <= ptr_inc(rd_ptr);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Buffer storage; contents are only observed through the valid-gated head.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= '{word: mem_rdata, pc: resp_pc};
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && fifo_full && !pop));

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: a latency-configurable in-order memory model pushes the
// expected {pc, word} of every granted fetch into a scoreboard; each decode
// pop is compared against the head. A second instance checks PC wrap.
module tb_ifetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_req, mem_gnt, mem_rvalid, instr_valid, instr_ready, redirect;
    logic [31:0] mem_addr, mem_rdata, instr, instr_pc, redirect_pc;

    logic        req2, gnt2, rv2, valid2, ready2, redir2;
    logic [31:0] addr2, rdata2, instr2, pc2, redir_pc2;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int lat = 1;
    bit gnt_block = 1'b0;

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] word; } exp_t;

    mreq_t       mq[$];
    exp_t        exp_q[$];
    logic [31:0] glog[$];
    int          gcyc[$];
    logic [31:0] plog[$];
    logic [31:0] g2[$], p2[$], p2w[$];
    mreq_t       mr;
    exp_t        se;
    bit          pv2 = 1'b0;
    logic [31:0] pa2;

    ifetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    ifetch #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .mem_req(req2), .mem_addr(addr2), .mem_gnt(gnt2),
        .mem_rvalid(rv2), .mem_rdata(rdata2),
        .instr_valid(valid2), .instr_ready(ready2),
        .instr(instr2), .instr_pc(pc2),
        .redirect(redir2), .redirect_pc(redir_pc2)
    );

    function automatic logic [31:0] mword(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[31:16] ^ a[15:0]};
    endfunction

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Main memory model: in-order, response 'lat' cycles after grant.
    initial begin
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mq.delete();
                mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
            end else begin
                if (mq.size() > 0 && mq[0].due <= cyc) begin
                    mr = mq.pop_front();
                    mem_rvalid = 1'b1;
                    mem_rdata  = mword(mr.addr);
                end else begin
                    mem_rvalid = 1'b0;
                    mem_rdata  = '0;
                end
                mem_gnt = !gnt_block;
                if (mem_req && !gnt_block) begin
                    mq.push_back('{addr: mem_addr, due: cyc + lat});
                    exp_q.push_back('{pc: mem_addr, word: mword(mem_addr)});
                    glog.push_back(mem_addr);
                    gcyc.push_back(cyc);
                end
            end
        end
    end

    // Scoreboard: redirect/reset invalidate everything not yet delivered.
    initial forever begin
        @(negedge clk);
        if (!rst_n || redirect) begin
            exp_q.delete();
        end else if (instr_valid && instr_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_pop got_pc=%h got_instr=%h", instr_pc, instr);
            end else begin
                se = exp_q.pop_front();
                if (instr_pc !== se.pc || instr !== se.word) begin
                    failures++;
                    $display("FAIL sb_pop got=%h/%h exp=%h/%h", instr_pc, instr, se.pc, se.word);
                end
            end
            plog.push_back(instr_pc);
        end
    end

    // Zero-wait memory for the wrap instance.
    initial begin
        gnt2 = 1'b0; rv2 = 1'b0; rdata2 = '0; ready2 = 1'b1; redir2 = 1'b0; redir_pc2 = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv2 = 1'b0; gnt2 = 1'b0; rv2 = 1'b0; rdata2 = '0;
            end else begin
                rv2    = pv2;
                rdata2 = pv2 ? mword(pa2) : '0;
                gnt2   = 1'b1;
                pv2    = req2;
                pa2    = addr2;
                if (req2) g2.push_back(addr2);
                if (valid2) begin
                    p2.push_back(pc2);
                    p2w.push_back(instr2);
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0;
        repeat (2) @(negedge clk);
        glog.delete(); gcyc.delete(); plog.delete();
        g2.delete(); p2.delete(); p2w.delete();
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #2;
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_instr_valid got=%b exp=0", instr_valid); end
        checks++; if (instr !== 32'h0 || instr_pc !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h/%h exp=0/0", instr, instr_pc); end
        checks++; if (req2 !== 1'b0) begin failures++; $display("FAIL reset_wrap_req got=%b exp=0", req2); end
    endtask

    task automatic test_stream();
        int k, r0;
        lat = 1; gnt_block = 1'b0; instr_ready = 1'b1;
        do_reset();
        r0 = cyc;
        k = 0;
        while (k < 10) begin
            @(negedge clk);
            if (instr_valid) break;
            k++;
        end
        checks++; if (k != 2) begin failures++; $display("FAIL stream_first_valid got=%0d exp=2", k); end
        for (int i = 0; i < 60 && plog.size() < 6; i++) @(negedge clk);
        checks++;
        if (plog.size() < 6 || glog.size() < 6) begin
            failures++; $display("FAIL stream_count got=%0d exp=6", plog.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++; if (glog[i] !== 32'(4 * i)) begin failures++; $display("FAIL stream_addr[%0d] got=%h exp=%h", i, glog[i], 32'(4 * i)); end
                checks++; if (plog[i] !== 32'(4 * i)) begin failures++; $display("FAIL stream_pc[%0d] got=%h exp=%h", i, plog[i], 32'(4 * i)); end
            end
            checks++; if (gcyc[0] != r0 || gcyc[1] != r0 + 1) begin failures++; $display("FAIL stream_gnt_cycles got=%0d,%0d exp=%0d,%0d", gcyc[0], gcyc[1], r0, r0 + 1); end
        end
    endtask

    task automatic test_stall();
        int x;
        lat = 1; gnt_block = 1'b0; instr_ready = 1'b0;
        do_reset();
        repeat (8) @(negedge clk);
        checks++;
        if (glog.size() != 2) begin failures++; $display("FAIL stall_grants got=%0d exp=2", glog.size()); end
        else if (glog[0] !== 32'h0 || glog[1] !== 32'h4) begin failures++; $display("FAIL stall_grants got=%h,%h exp=0,4", glog[0], glog[1]); end
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL stall_mem_req got=%b exp=0", mem_req); end
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin failures++; $display("FAIL stall_head got=%b/%h exp=1/0", instr_valid, instr_pc); end
        @(posedge clk); #1 instr_ready = 1'b1;
        x = cyc;
        for (int i = 0; i < 20 && glog.size() < 3; i++) @(negedge clk);
        checks++;
        if (glog.size() < 3) begin failures++; $display("FAIL stall_resume got=%0d exp=3", glog.size()); end
        else if (glog[2] !== 32'h8 || gcyc[2] != x + 1) begin failures++; $display("FAIL stall_resume got=%h@%0d exp=8@%0d", glog[2], gcyc[2], x + 1); end
        for (int i = 0; i < 20 && plog.size() < 2; i++) @(negedge clk);
        checks++;
        if (plog.size() < 2) begin failures++; $display("FAIL stall_pops got=%0d exp=2", plog.size()); end
        else if (plog[0] !== 32'h0 || plog[1] !== 32'h4) begin failures++; $display("FAIL stall_pops got=%h,%h exp=0,4", plog[0], plog[1]); end
    endtask

    task automatic test_gnt_stall();
        lat = 1; instr_ready = 1'b1; gnt_block = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin failures++; $display("FAIL gnt_hold[%0d] got=%b/%h exp=1/0", i, mem_req, mem_addr); end
        end
        @(posedge clk); #1 gnt_block = 1'b0;
        for (int i = 0; i < 10 && glog.size() < 1; i++) @(negedge clk);
        checks++; if (glog.size() < 1 || glog[0] !== 32'h0) begin failures++; $display("FAIL gnt_first got_n=%0d exp_addr=0", glog.size()); end
        @(negedge clk);
        checks++; if (mem_addr !== 32'h4) begin failures++; $display("FAIL gnt_advance got=%h exp=4", mem_addr); end
    endtask

    task automatic test_redirect();
        lat = 3; instr_ready = 1'b1; gnt_block = 1'b1;
        do_reset();
        redirect = 1'b1; redirect_pc = 32'h10;
        @(posedge clk); #1 redirect = 1'b0; gnt_block = 1'b0;
        for (int i = 0; i < 10 && glog.size() < 2; i++) @(negedge clk);
        checks++;
        if (glog.size() != 2 || glog[0] !== 32'h10 || glog[1] !== 32'h14) begin failures++; $display("FAIL redir_setup got_n=%0d exp=2 (0x10,0x14)", glog.size()); end
        @(posedge clk); #1 redirect = 1'b1; redirect_pc = 32'h103;
        @(negedge clk);
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL redir_req_low got=%b exp=0", mem_req); end
        @(posedge clk); #1 redirect = 1'b0;
        @(negedge clk);
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL redir_valid_low got=%b exp=0", instr_valid); end
        for (int i = 0; i < 20 && glog.size() < 3; i++) @(negedge clk);
        checks++; if (glog.size() < 3 || glog[2] !== 32'h100) begin failures++; $display("FAIL redir_new_addr got_n=%0d exp_addr=100", glog.size()); end
        for (int i = 0; i < 20 && plog.size() < 1; i++) @(negedge clk);
        checks++; if (plog.size() < 1 || plog[0] !== 32'h100) begin failures++; $display("FAIL redir_first_pc got_n=%0d exp_pc=100", plog.size()); end
    endtask

    task automatic test_back_to_back();
        lat = 3; instr_ready = 1'b1; gnt_block = 1'b0;
        do_reset();
        for (int i = 0; i < 10 && glog.size() < 2; i++) @(negedge clk);
        @(posedge clk); #1 redirect = 1'b1; redirect_pc = 32'h200;
        @(posedge clk); #1 redirect_pc = 32'h300;
        @(posedge clk); #1 redirect = 1'b0;
        for (int i = 0; i < 20 && glog.size() < 3; i++) @(negedge clk);
        checks++; if (glog.size() < 3 || glog[2] !== 32'h300) begin failures++; $display("FAIL b2b_addr got_n=%0d exp_addr=300", glog.size()); end
        for (int i = 0; i < 30 && plog.size() < 2; i++) @(negedge clk);
        checks++;
        if (plog.size() < 2 || plog[0] !== 32'h300 || plog[1] !== 32'h304) begin failures++; $display("FAIL b2b_pcs got_n=%0d exp=300,304", plog.size()); end
    endtask

    task automatic test_wrap();
        logic [31:0] ea [3];
        ea[0] = 32'hFFFF_FFF8; ea[1] = 32'hFFFF_FFFC; ea[2] = 32'h0000_0000;
        lat = 1; gnt_block = 1'b0; instr_ready = 1'b1;
        do_reset();
        repeat (12) @(negedge clk);
        checks++;
        if (g2.size() < 3 || p2.size() < 3) begin
            failures++; $display("FAIL wrap_count got=%0d/%0d exp>=3", g2.size(), p2.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++; if (g2[i] !== ea[i]) begin failures++; $display("FAIL wrap_addr[%0d] got=%h exp=%h", i, g2[i], ea[i]); end
                checks++; if (p2[i] !== ea[i] || p2w[i] !== mword(ea[i])) begin failures++; $display("FAIL wrap_instr[%0d] got=%h/%h exp=%h/%h", i, p2[i], p2w[i], ea[i], mword(ea[i])); end
            end
        end
    endtask

    task automatic test_reset_mid();
        lat = 3; gnt_block = 1'b0; instr_ready = 1'b0;
        do_reset();
        repeat (5) @(negedge clk);
        checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL rmid_pre_valid got=%b exp=1", instr_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (instr_valid !== 1'b0 || mem_req !== 1'b0) begin failures++; $display("FAIL rmid_drop got=%b/%b exp=0/0", instr_valid, mem_req); end
        checks++; if (instr_pc !== 32'h0) begin failures++; $display("FAIL rmid_pc got=%h exp=0", instr_pc); end
        lat = 1; instr_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 20 && plog.size() < 2; i++) @(negedge clk);
        checks++; if (glog.size() < 1 || glog[0] !== 32'h0) begin failures++; $display("FAIL rmid_restart_addr got_n=%0d exp_addr=0", glog.size()); end
        checks++;
        if (plog.size() < 2 || plog[0] !== 32'h0 || plog[1] !== 32'h4) begin failures++; $display("FAIL rmid_restart_pcs got_n=%0d exp=0,4", plog.size()); end
    endtask

    initial begin
        rst_n = 1'b1; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        test_reset();
        test_stream();
        test_stall();
        test_gnt_stall();
        test_redirect();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
